doorlock_entry: RTL and testbench

Upstream input stage for `doorlock`. Collects a 4-bit binary passcode from debounced keypad pulses, sequences the 2-bit `state` code consumed downstream (00 idle, 01 entry, 10 check), and presents the entered code on `ps_num`. Counts failed checks using `door_open` fed back from `doorlock`, and enforces a timed lockout after repeated failures.

---
 rtl/doorlock_entry.sv | 140 ++++++++++++++
 tb/tb_doorlock_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/doorlock_entry.sv
// Keypad front end for doorlock: shifts in a 4-bit code, sequences idle/entry/check,
// counts failed checks from the door_open feedback and enforces a timed lockout.
module doorlock_entry #(
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 32,
  localparam int FAIL_W        = (MAX_FAILS < 4) ? 2 : $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic              key_bit,
  input  logic              key_clear,
  input  logic              key_enter,
  input  logic              door_open,
  output logic [1:0]        state,
  output logic [3:0]        ps_num,
  output logic [2:0]        bit_cnt,
  output logic              lockout,
  output logic [1:0]        dbg_fsm,
  output logic [FAIL_W-1:0] dbg_fail_cnt
);

  localparam int MAX_HT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_FL = (MAX_FAILS > LOCKOUT_CYCLES) ? MAX_FAILS : LOCKOUT_CYCLES;
  localparam int MAX_P  = (MAX_HT > MAX_FL) ? MAX_HT : MAX_FL;
  localparam int TW     = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_ENTRY = 2'b01;
  localparam logic [1:0] CODE_CHECK = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCKOUT = 2'd3
  } fsm_t;

  fsm_t              fsm_q;
  logic [TW-1:0]     timer_q;
  logic [FAIL_W-1:0] fail_cnt_q;
  logic [FAIL_W-1:0] fail_nxt;

  // The fail count must already include this check's verdict when the hold ends,
  // even if the hold is a single cycle, so the sampled result is formed here.
  always_comb begin
    fail_nxt = fail_cnt_q;
    if (fsm_q == S_CHECK && timer_q == '0) begin
      if (door_open)
        fail_nxt = '0;
      else if (fail_cnt_q != FAIL_W'(MAX_FAILS))
        fail_nxt = fail_cnt_q + FAIL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      state      <= CODE_IDLE;
      ps_num     <= 4'b0000;
      bit_cnt    <= 3'd0;
      lockout    <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (key_valid) begin
            fsm_q   <= S_ENTRY;
            state   <= CODE_ENTRY;
            ps_num  <= {3'b000, key_bit};
            bit_cnt <= 3'd1;
            timer_q <= '0;
          end
        end
        S_ENTRY: begin
          // Only accepted actions restart the inactivity timer.
          if (key_clear) begin
            ps_num  <= 4'b0000;
            bit_cnt <= 3'd0;
            timer_q <= '0;
          end else if (key_enter && bit_cnt == 3'd4) begin
            fsm_q   <= S_CHECK;
            state   <= CODE_CHECK;
            timer_q <= '0;
          end else if (key_valid && bit_cnt != 3'd4) begin
            ps_num  <= {ps_num[2:0], key_bit};
            bit_cnt <= bit_cnt + 3'd1;
            timer_q <= '0;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            fsm_q   <= S_IDLE;
            state   <= CODE_IDLE;
            ps_num  <= 4'b0000;
            bit_cnt <= 3'd0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_CHECK: begin
          fail_cnt_q <= fail_nxt;
          if (timer_q == TW'(HOLD_CYCLES - 1)) begin
            state   <= CODE_IDLE;
            ps_num  <= 4'b0000;
            bit_cnt <= 3'd0;
            timer_q <= '0;
            if (fail_nxt == FAIL_W'(MAX_FAILS)) begin
              fsm_q   <= S_LOCKOUT;
              lockout <= 1'b1;
            end else begin
              fsm_q   <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
            fsm_q      <= S_IDLE;
            lockout    <= 1'b0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          fsm_q <= S_IDLE;
          state <= CODE_IDLE;
        end
      endcase
    end
  end

  assign dbg_fsm      = fsm_q;
  assign dbg_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_doorlock_entry.sv
// Directed bench for doorlock_entry: each step applies key pulses for one clock and
// checks the registered outputs one time unit after the rising edge.
module tb_doorlock_entry;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic       key_bit;
  logic       key_clear;
  logic       key_enter;
  logic       door_open;
  logic [1:0] state;
  logic [3:0] ps_num;
  logic [2:0] bit_cnt;
  logic       lockout;
  logic [1:0] dbg_fsm;
  logic [1:0] dbg_fail_cnt;

  int vectors;
  int miscompares;

  doorlock_entry dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_bit      (key_bit),
    .key_clear    (key_clear),
    .key_enter    (key_enter),
    .door_open    (door_open),
    .state        (state),
    .ps_num       (ps_num),
    .bit_cnt      (bit_cnt),
    .lockout      (lockout),
    .dbg_fsm      (dbg_fsm),
    .dbg_fail_cnt (dbg_fail_cnt)
  );

  // Stand-in for doorlock: the correct code is 1101.
  assign door_open = (state == 2'b10) && (ps_num == 4'b1101);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic [3:0] ps,
                          input logic [2:0] cnt, input logic lk);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".ps_num"}, 8'(ps_num), 8'(ps));
    chk({tag, ".bit_cnt"}, 8'(bit_cnt), 8'(cnt));
    chk({tag, ".lockout"}, 8'(lockout), 8'(lk));
  endtask

  task automatic step(input logic v, input logic b, input logic c, input logic e);
    key_valid = v;
    key_bit   = b;
    key_clear = c;
    key_enter = e;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    key_clear = 1'b0;
    key_enter = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) step(1'b1, code[i], 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Walks the 8-cycle check window starting on its first cycle.
  task automatic run_check(input string tag, input logic [3:0] code, input logic [1:0] fail_exp,
                           input logic lk_exp);
    chk_outs({tag, ".c1"}, 2'b10, code, 3'd4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk({tag, ".fail"}, 8'(dbg_fail_cnt), 8'(fail_exp));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk_outs({tag, ".hold"}, 2'b10, code, 3'd4, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs({tag, ".exit"}, 2'b00, 4'b0000, 3'd0, lk_exp);
  endtask

  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk_outs(tag, 2'b00, 4'b0000, 3'd0, 1'b0);
    chk({tag, ".fsm"}, 8'(dbg_fsm), 8'd0);
    chk({tag, ".fail"}, 8'(dbg_fail_cnt), 8'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    key_valid   = 1'b0;
    key_bit     = 1'b0;
    key_clear   = 1'b0;
    key_enter   = 1'b0;

    #12;
    chk_outs("reset", 2'b00, 4'b0000, 3'd0, 1'b0);
    chk("reset.fsm", 8'(dbg_fsm), 8'd0);
    chk("reset.fail", 8'(dbg_fail_cnt), 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Correct code 1101.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("ok.k1", 2'b01, 4'b0001, 3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("ok.k2", 2'b01, 4'b0011, 3'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("ok.k3", 2'b01, 4'b0110, 3'd3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("ok.k4", 2'b01, 4'b1101, 3'd4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_check("ok", 4'b1101, 2'd0, 1'b0);

    // Three wrong codes lead to lockout.
    enter_code(4'b0000);
    run_check("bad1", 4'b0000, 2'd1, 1'b0);
    enter_code(4'b0000);
    run_check("bad2", 4'b0000, 2'd2, 1'b0);
    enter_code(4'b0000);
    run_check("bad3", 4'b0000, 2'd3, 1'b1);
    for (int i = 0; i < 31; i++) begin
      step(1'b1, i[0], i[1], i[2]);
      chk_outs("lock.hold", 2'b00, 4'b0000, 3'd0, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("lock.end", 2'b00, 4'b0000, 3'd0, 1'b0);
    chk("lock.end.fail", 8'(dbg_fail_cnt), 8'd0);
    enter_code(4'b1101);
    run_check("after_lock", 4'b1101, 2'd0, 1'b0);

    // Fifth bit ignored; enter with three bits ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("five", 2'b01, 4'b1101, 3'd4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_outs("clear", 2'b01, 4'b0000, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("enter3", 2'b01, 4'b0101, 3'd3, 1'b0);

    // Inactivity timeout; a key on the 15th quiet cycle restarts the count.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("to.k2", 2'b01, 4'b0010, 3'd2, 1'b0);
    idle(14);
    chk_outs("to.q14", 2'b01, 4'b0010, 3'd2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("to.k15", 2'b01, 4'b0101, 3'd3, 1'b0);
    idle(15);
    chk_outs("to.q15", 2'b01, 4'b0101, 3'd3, 1'b0);
    idle(1);
    chk_outs("to.fire", 2'b00, 4'b0000, 3'd0, 1'b0);
    chk("to.fail", 8'(dbg_fail_cnt), 8'd0);

    // Clear/enter ignored in idle; clear beats enter in entry.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk_outs("idle.ce", 2'b00, 4'b0000, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("ce.full", 2'b01, 4'b1011, 3'd4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk_outs("ce.clear", 2'b01, 4'b0000, 3'd0, 1'b0);

    // Reset on the third check cycle.
    enter_code(4'b1101);
    chk_outs("rc.c1", 2'b10, 4'b1101, 3'd4, 1'b0);
    idle(2);
    chk_outs("rc.c3", 2'b10, 4'b1101, 3'd4, 1'b0);
    pulse_reset("rst_check");
    idle(1);
    chk_outs("rc.after", 2'b00, 4'b0000, 3'd0, 1'b0);

    // Reset in the middle of a lockout.
    enter_code(4'b0110);
    run_check("rl1", 4'b0110, 2'd1, 1'b0);
    enter_code(4'b0110);
    run_check("rl2", 4'b0110, 2'd2, 1'b0);
    enter_code(4'b0110);
    run_check("rl3", 4'b0110, 2'd3, 1'b1);
    idle(5);
    chk_outs("rl.lock", 2'b00, 4'b0000, 3'd0, 1'b1);
    pulse_reset("rst_lock");
    enter_code(4'b1101);
    run_check("post_rst", 4'b1101, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
